game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter: N_BRICKS, 18, bricks per level.
REQ-002 Parameter: N_LIVES, 3, lives per game (1..3).
REQ-003 Parameter: N_LEVELS, 4, levels per game (1..4).
REQ-004 Parameter: SERVE_FRAMES, 60, frame ticks of serve delay (1..255).
REQ-005 Port: clk  in  1  system clock.
REQ-006 Port: reset  in  1  reset, asynchronous, active-high.
REQ-007 Port: frame_tick  in  1  one-cycle pulse per video frame (refresh tick).
REQ-008 Port: btn_start  in  1  raw start button, asynchronous to clk.
REQ-009 Port: ball_lost  in  1  one-cycle pulse when the ball passes below the paddle.
REQ-010 Port: brick_hit  in  1  one-cycle pulse per brick destroyed.
REQ-011 Port: run  out  1  enables ball and paddle motion.
REQ-012 Port: serve  out  1  one-cycle pulse; ball returns to its serve position.
REQ-013 Port: bricks_reload  out  1  one-cycle pulse; brick field restored to all-present.
REQ-014 Port: level  out  2  current level, 0-based.
REQ-015 Port: lives  out  2  remaining lives.
REQ-016 Port: ball_speed  out  3  ball step per frame, equal to level+1.
REQ-017 Port: level_lamps  out  4  bit i set once level i is cleared.
REQ-018 Port: score  out  12  bricks destroyed this game, saturating at 4095.
REQ-019 Port: win  out  1  high in OVER when every level was cleared.
REQ-020 Port: state  out  3  current FSM state encoding, for debug.

Function
REQ-021 The FSM SHALL have the states IDLE, SERVE, PLAY, LOST, CLEAR and OVER.
REQ-022 btn_start SHALL pass through a 2-flop synchronizer and a rising-edge detector; "start" in this document means that one-cycle edge, occurring 3 cycles after the raw rise.
REQ-023 IDLE or OVER, on start -> SERVE, with the following loads: lives=N_LIVES, level=0, score=0, level_lamps=0, win=0, bricks_left=N_BRICKS, bricks_reload pulsed.
REQ-024 serve SHALL be high exactly in the first cycle of every SERVE visit; the serve counter SHALL clear on entry.
REQ-025 SERVE: the counter SHALL increment on each frame_tick; on the SERVE_FRAMES-th tick the next state SHALL be PLAY.
REQ-026 run SHALL be 1 only in PLAY, registered with the state.
REQ-027 PLAY, brick_hit with bricks_left>0: bricks_left SHALL decrement and score SHALL increment (saturating); bricks_left reaching 0 -> CLEAR.
REQ-028 PLAY, ball_lost -> LOST.
REQ-029 brick_hit and ball_lost in the same cycle: the hit SHALL be counted first; if it was the last brick, the next state SHALL be CLEAR and the loss SHALL be discarded.
REQ-030 brick_hit and ball_lost outside PLAY SHALL be ignored; brick_hit with bricks_left==0 SHALL be ignored.
REQ-031 LOST (one cycle): lives SHALL decrement; if lives was 1, next state SHALL be OVER with win=0, else SERVE.
REQ-032 CLEAR (one cycle): level_lamps[level] SHALL be set; if level==N_LEVELS-1, next state SHALL be OVER with win=1; else level SHALL increment, bricks_left SHALL reload to N_BRICKS, bricks_reload SHALL pulse, and next state SHALL be SERVE.
REQ-033 OVER SHALL hold all counters until start.
REQ-034 bricks_left SHALL be 5 bits wide; score SHALL saturate at 12'hFFF and never wrap.
REQ-035 Every output SHALL be registered; the outputs SHALL have no combinational path from the inputs.

Reset
REQ-036 Reset SHALL give: state=IDLE, run=0, serve=0, bricks_reload=0, level=0, lives=N_LIVES, level_lamps=0, score=0, win=0, bricks_left=N_BRICKS, serve counter=0, synchronizer flops=0.
REQ-037 Reset asserted mid-game SHALL abort immediately to the reset values with no serve pulse and no bricks_reload pulse.

Structure
REQ-038 The state encoding and the N_BRICKS, N_LIVES, N_LEVELS and SERVE_FRAMES defaults SHALL live in the shared package game_pkg.
REQ-039 The start synchronizer and edge detector SHALL be the sub-module btn_edge; all other logic SHALL stay in game_sequencer.

Verification
REQ-040 Reset, then raise btn_start -> SERVE entered after 3 cycles with serve=1 and bricks_reload=1 for one cycle; lives=3 and level=0.
REQ-041 SERVE_FRAMES=4, 4 frame_ticks -> run=1 in the cycle after the 4th tick; fewer ticks -> run remains 0.
REQ-042 18 brick_hit pulses in PLAY -> CLEAR, then level_lamps=0001, level=1, ball_speed=2, bricks_reload pulse, serve pulse; score=18.
REQ-043 3 ball_lost pulses, each in PLAY -> lives 2, 1, then OVER with win=0; a further brick_hit leaves score unchanged.
REQ-044 Last brick_hit and ball_lost in the same cycle -> CLEAR, with lives unchanged.
REQ-045 Clear all 4 levels -> OVER, win=1, level_lamps=1111; reset asserted mid-PLAY -> all reset values the same cycle, with no pulses.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: parameter defaults, the FSM
// state encoding, and a saturating score increment helper.
package game_pkg;

  localparam int DEF_N_BRICKS     = 18;
  localparam int DEF_N_LIVES      = 3;
  localparam int DEF_N_LEVELS     = 4;
  localparam int DEF_SERVE_FRAMES = 60;

  // Plain constants rather than an enum so the encoding is stable on the
  // debug port and easy to compare against in checkers.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_LOST  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  // Score never wraps: it sticks at all-ones.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Start button conditioning: two-flop synchronizer followed by a
// rising-edge detector.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   btn_in     : raw button, asynchronous to clk
//   start      : one-cycle pulse on a synchronized rising edge; high in the
//                cycle after the second synchronizer flop captures the rise,
//                so the consuming FSM changes state on the third clock edge
//                after the raw rise.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic start
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign start = sync2 & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller for a brick-breaker style game: serve delay, play,
// life loss, level clear and game over, with score and level tracking.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   frame_tick    : one pulse per video frame, paces the serve delay
//   btn_start     : raw start button (synchronized internally)
//   ball_lost     : pulse when the ball drops below the paddle
//   brick_hit     : pulse per brick destroyed
//   run           : ball/paddle motion enable (high only in PLAY)
//   serve         : pulse in the first cycle of every SERVE visit
//   bricks_reload : pulse when the brick field is restored
//   level, lives, ball_speed, level_lamps, score, win : game status
//   state         : FSM state encoding for debug
// All outputs come straight from flops.
module game_sequencer
  import game_pkg::*;
#(
  parameter int N_BRICKS     = DEF_N_BRICKS,
  parameter int N_LIVES      = DEF_N_LIVES,
  parameter int N_LEVELS     = DEF_N_LEVELS,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        ball_lost,
  input  logic        brick_hit,
  output logic        run,
  output logic        serve,
  output logic        bricks_reload,
  output logic [1:0]  level,
  output logic [1:0]  lives,
  output logic [2:0]  ball_speed,
  output logic [3:0]  level_lamps,
  output logic [11:0] score,
  output logic        win,
  output logic [2:0]  state
);

  logic       start;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] bricks_q, bricks_d;
  logic [2:0] state_d;
  logic [1:0] level_d, lives_d;
  logic [3:0] lamps_d;
  logic [11:0] score_d;
  logic       win_d;
  logic       serve_d, reload_d;

  btn_edge u_btn_edge (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_start),
    .start  (start)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt_q;
    bricks_d = bricks_q;
    level_d  = level;
    lives_d  = lives;
    lamps_d  = level_lamps;
    score_d  = score;
    win_d    = win;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_SERVE;
          lives_d  = 2'(N_LIVES);
          level_d  = 2'd0;
          score_d  = 12'd0;
          lamps_d  = 4'd0;
          win_d    = 1'b0;
          bricks_d = 5'(N_BRICKS);
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == 8'(SERVE_FRAMES - 1)) state_d = ST_PLAY;
          else                               cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_PLAY: begin
        // A hit is counted before a simultaneous loss; clearing the last
        // brick wins over the loss.
        if (brick_hit && bricks_q != 5'd0) begin
          bricks_d = bricks_q - 5'd1;
          score_d  = sat_inc12(score);
          if (bricks_q == 5'd1) state_d = ST_CLEAR;
          else if (ball_lost)   state_d = ST_LOST;
        end else if (ball_lost) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        lives_d = lives - 2'd1;
        if (lives == 2'd1) begin
          state_d = ST_OVER;
          win_d   = 1'b0;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_CLEAR: begin
        lamps_d[level] = 1'b1;
        if (level == 2'(N_LEVELS - 1)) begin
          state_d = ST_OVER;
          win_d   = 1'b1;
        end else begin
          level_d  = level + 2'd1;
          bricks_d = 5'(N_BRICKS);
          state_d  = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every SERVE entry restarts the frame count and fires one serve pulse;
    // entries from a new game or a cleared level also refill the bricks.
    serve_d  = (state_d == ST_SERVE) && (state != ST_SERVE);
    reload_d = (state_d == ST_SERVE) &&
               (state == ST_IDLE || state == ST_OVER || state == ST_CLEAR);
    if (serve_d) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      run           <= 1'b0;
      serve         <= 1'b0;
      bricks_reload <= 1'b0;
      level         <= 2'd0;
      lives         <= 2'(N_LIVES);
      ball_speed    <= 3'd1;
      level_lamps   <= 4'd0;
      score         <= 12'd0;
      win           <= 1'b0;
      bricks_q      <= 5'(N_BRICKS);
      cnt_q         <= 8'd0;
    end else begin
      state         <= state_d;
      run           <= (state_d == ST_PLAY);
      serve         <= serve_d;
      bricks_reload <= reload_d;
      level         <= level_d;
      lives         <= lives_d;
      ball_speed    <= {1'b0, level_d} + 3'd1;
      level_lamps   <= lamps_d;
      score         <= score_d;
      win           <= win_d;
      bricks_q      <= bricks_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
